// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake.
//
// Six operations on WIDTH-bit unsigned operands. Add, subtract and xor complete in one
// cycle. Multiply uses a shift-add loop and divide/modulo use a restoring loop. Each loop
// resolves one bit per cycle, so no wide multiplier or divider sits in a single cycle.
//
// Build option: define SEQ_ALU_FAST_MUL_EN to compute multiply with a one-cycle
// combinational multiplier. In that build the MUL state does not exist.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    request, sampled only in IDLE; alu_op/in1/in2 are captured with it
//   alu_op   1 add, 2 sub, 3 mul, 4 div, 5 mod, 6 xor, 0/7 no-op (result = in2 OP in1)
//   alu_out  registered result
//   z        result MSB set or result zero
//   dbz      divide-by-zero flag of the last completed non-no-op
//   busy     iterative operation in progress
//   done     one-cycle pulse when alu_out/z/dbz are updated
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             dbz,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [2:0] OpAdd = 3'd1;
  localparam logic [2:0] OpSub = 3'd2;
  localparam logic [2:0] OpMul = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4;
  localparam logic [2:0] OpMod = 3'd5;
  localparam logic [2:0] OpXor = 3'd6;

`ifdef SEQ_ALU_FAST_MUL_EN
  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  // opa: in1 (multiplier shifting right, or divisor).
  // opb: in2 (multiplicand shifting left, or dividend shifting out / quotient shifting in).
  // acc: partial product or partial remainder.
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             z_q, z_d;
  logic             dbz_q, dbz_d;

  // Shared next-result path: any state that finishes an op sets upd.
  logic             upd;
  logic [WIDTH-1:0] res;
  logic             res_dbz;

  // Restoring-division step.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

`ifndef SEQ_ALU_FAST_MUL_EN
  logic [WIDTH-1:0] mul_sum;
`endif

  always_comb begin
    rem_shift = {acc_q, opb_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opa_q};
    // No borrow out of the subtraction means the divisor fits: keep the difference.
    q_bit     = ~rem_diff[WIDTH];
    rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {opb_q[WIDTH-2:0], q_bit};
`ifndef SEQ_ALU_FAST_MUL_EN
    mul_sum   = acc_q + (opb_q & {WIDTH{opa_q[0]}});
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    z_d       = z_q;
    dbz_d     = dbz_q;
    upd       = 1'b0;
    res       = '0;
    res_dbz   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = alu_op;
          opa_d = in1;
          opb_d = in2;
          acc_d = '0;
          cnt_d = '0;
          case (alu_op)
            OpAdd: begin
              res     = in2 + in1;
              upd     = 1'b1;
              state_d = StDone;
            end
            OpSub: begin
              res     = in2 - in1;
              upd     = 1'b1;
              state_d = StDone;
            end
            OpXor: begin
              res     = in2 ^ in1;
              upd     = 1'b1;
              state_d = StDone;
            end
            OpMul: begin
`ifdef SEQ_ALU_FAST_MUL_EN
              res     = in2 * in1;
              upd     = 1'b1;
              state_d = StDone;
`else
              state_d = StMul;
`endif
            end
            OpDiv, OpMod: begin
              if (in1 == '0) begin
                res     = (alu_op == OpDiv) ? '1 : in2;
                res_dbz = 1'b1;
                upd     = 1'b1;
                state_d = StDone;
              end else begin
                state_d = StDiv;
              end
            end
            // No-op: pulse done without touching the result registers.
            default: state_d = StDone;
          endcase
        end
      end

`ifndef SEQ_ALU_FAST_MUL_EN
      StMul: begin
        acc_d = mul_sum;
        opb_d = opb_q << 1;
        opa_d = opa_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          res     = mul_sum;
          upd     = 1'b1;
          state_d = StDone;
        end
      end
`endif

      StDiv: begin
        acc_d = rem_next;
        opb_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          res     = (op_q == OpMod) ? rem_next : quo_next;
          upd     = 1'b1;
          state_d = StDone;
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (upd) begin
      alu_out_d = res;
      z_d       = res[WIDTH-1] | ~|res;
      dbz_d     = res_dbz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      z_q       <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      z_q       <= z_d;
      dbz_q     <= dbz_d;
    end
  end

  assign alu_out = alu_out_q;
  assign z       = z_q;
  assign dbz     = dbz_q;
  assign done    = (state_q == StDone);
`ifdef SEQ_ALU_FAST_MUL_EN
  assign busy    = (state_q == StDiv);
`else
  assign busy    = (state_q == StMul) || (state_q == StDiv);
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a reference model computes each result when an op is issued and
// pushes it to a scoreboard; a negedge monitor pops and compares on every done pulse.
module tb_seq_alu;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   alu_op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] alu_out;
  logic         z;
  logic         dbz;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .alu_op  (alu_op),
    .in1     (in1),
    .in2     (in2),
    .alu_out (alu_out),
    .z       (z),
    .dbz     (dbz),
    .busy    (busy),
    .done    (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] out;
    logic         z;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (last completed non-no-op result).
  logic [W-1:0] m_out = '0;
  logic         m_z   = 1'b0;
  logic         m_dbz = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("alu_out", 32'(alu_out), 32'(mon_e.out));
        check_val("z", 32'(z), 32'(mon_e.z));
        check_val("dbz", 32'(dbz), 32'(mon_e.dbz));
        check_val("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        check_val("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Drives start for one cycle (start cycle = cyc at entry negedge) and queues the expectation.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] r;
    logic         iter;
    @(negedge clk);
    alu_op = op;
    in1    = a;
    in2    = b;
    start  = 1'b1;
    r      = m_out;
    iter   = 1'b0;
    case (op)
      3'd1: r = b + a;
      3'd2: r = b - a;
      3'd3: begin
        r = b * a;
`ifndef SEQ_ALU_FAST_MUL_EN
        iter = 1'b1;
`endif
      end
      3'd4: begin
        r    = (a == 0) ? {W{1'b1}} : b / a;
        iter = (a != 0);
      end
      3'd5: begin
        r    = (a == 0) ? b : b % a;
        iter = (a != 0);
      end
      3'd6: r = b ^ a;
      default: r = m_out;
    endcase
    if (op != 3'd0 && op != 3'd7) begin
      m_out = r;
      m_z   = r[W-1] | (r == 0);
      m_dbz = (op == 3'd4 || op == 3'd5) && (a == 0);
    end
    e.out = m_out;
    e.z   = m_z;
    e.dbz = m_dbz;
    e.cyc = cyc + (iter ? int'(W) + 1 : 1);
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    alu_op = 3'($urandom);
    in1    = W'($urandom);
    in2    = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check_val("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held together with a start request: the start must be dropped.
    rst    = 1'b1;
    start  = 1'b1;
    alu_op = 3'd1;
    in1    = 16'd5;
    in2    = 16'd3;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_val("rst_alu_out", 32'(alu_out), 32'd0);
    check_val("rst_z", 32'(z), 32'd0);
    check_val("rst_dbz", 32'(dbz), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);

    issue(3'd1, 16'd5, 16'd3);            // 0x0008
    drain();
    issue(3'd2, 16'd5, 16'd3);            // 0xFFFE, z
    drain();
    issue(3'd2, 16'h1234, 16'h1234);      // 0, z
    drain();

    // Multiply 300*300 = 0x5F90 (low 16 bits); busy across every iteration.
    issue(3'd3, 16'd300, 16'd300);
`ifndef SEQ_ALU_FAST_MUL_EN
    for (int k = 0; k < int'(W); k++) begin
      check_val("busy_mul", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check_val("busy_mul_end", 32'(busy), 32'd0);
`endif
    drain();

    // Divide with a start pulse mid-iteration that must be ignored.
    issue(3'd4, 16'd7, 16'd100);          // 14
    repeat (3) @(negedge clk);
    check_val("busy_div", 32'(busy), 32'd1);
    start  = 1'b1;
    alu_op = 3'd1;
    @(negedge clk);
    start = 1'b0;
    drain();
    issue(3'd5, 16'd7, 16'd100);          // 2
    drain();

    issue(3'd4, 16'd0, 16'd1234);         // dbz: 0xFFFF
    drain();
    issue(3'd0, 16'd1, 16'd1);            // no-op holds
    drain();
    issue(3'd6, 16'h00F0, 16'h0F0F);      // 0x0FFF, dbz cleared
    drain();
    issue(3'd7, 16'd9, 16'd9);            // no-op holds
    drain();
    issue(3'd5, 16'd0, 16'h8001);         // dbz: in2
    drain();
    issue(3'd4, 16'd1, 16'hFFFF);         // divisor 1
    drain();
    issue(3'd5, 16'hFFFF, 16'hFFFE);      // divisor > dividend
    drain();

    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      issue(3'($urandom_range(0, 7)), a, W'($urandom));
      drain();
    end

    // Reset mid-multiply: outputs clear and the pending result never appears.
    issue(3'd3, 16'd300, 16'd300);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_out = '0;
    m_z   = 1'b0;
    m_dbz = 1'b0;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_alu_out", 32'(alu_out), 32'd0);
    check_val("midrst_z", 32'(z), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    repeat (25) @(negedge clk);

    issue(3'd1, 16'd5, 16'd3);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
